// File: rtl/wb_sequencer.sv
// Y86 write-back sequencer: serialises the E and M register writes of one retiring
// instruction onto a single register-file port. Optional WB_SAME_DST_MERGE_EN drops the E write when it targets the same register as the M write.
module wb_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_code,
    input  logic        cnd,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    output logic        rf_we,
    output logic [3:0]  rf_addr,
    output logic [63:0] rf_data,
    output logic        wb_done,
    output logic        inv_code
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [1:0] {IDLE, WR_E, WR_M, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        skip_e;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  dst_e_q;
    logic [3:0]  dst_m_q;
    logic [63:0] val_e_q;
    logic [63:0] val_m_q;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (in_code)
            4'h2:                      dst_e = cnd ? rb : REG_NONE;
            4'h3, 4'h6:                dst_e = rb;
            4'h8, 4'h9, 4'hA:          dst_e = REG_RSP;
            4'hB: begin
                dst_e = REG_RSP;
                dst_m = ra;
            end
            4'h5:                      dst_m = ra;
            default: begin
                dst_e = REG_NONE;
                dst_m = REG_NONE;
            end
        endcase
    end

`ifdef WB_SAME_DST_MERGE_EN
    // The M write lands last anyway, so an E write to the same register is redundant.
    assign skip_e = (dst_e == dst_m) && (dst_m != REG_NONE);
`else
    assign skip_e = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dst_e_q  <= REG_NONE;
            dst_m_q  <= REG_NONE;
            val_e_q  <= '0;
            val_m_q  <= '0;
            inv_code <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                dst_e_q <= dst_e;
                dst_m_q <= dst_m;
                val_e_q <= val_e;
                val_m_q <= val_m;
                if (in_code > 4'hB)
                    inv_code <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        rf_we      = 1'b0;
        rf_addr    = REG_NONE;
        rf_data    = '0;
        wb_done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dst_e != REG_NONE && !skip_e)
                        next_state = WR_E;
                    else if (dst_m != REG_NONE)
                        next_state = WR_M;
                    else
                        next_state = DONE;
                end
            end
            WR_E: begin
                rf_we      = 1'b1;
                rf_addr    = dst_e_q;
                rf_data    = val_e_q;
                next_state = (dst_m_q != REG_NONE) ? WR_M : DONE;
            end
            WR_M: begin
                rf_we      = 1'b1;
                rf_addr    = dst_m_q;
                rf_data    = val_m_q;
                next_state = DONE;
            end
            DONE: begin
                wb_done    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
module tb_wb_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        cnd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic        wb_done;
    logic        inv_code;

    int total = 0;
    int bad   = 0;

    logic        obs_we   [5];
    logic [3:0]  obs_addr [5];
    logic [63:0] obs_data [5];
    logic        obs_done [5];
    logic        obs_rdy  [5];

    wb_sequencer dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .cnd(cnd), .ra(ra), .rb(rb), .val_e(val_e), .val_m(val_m),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .wb_done(wb_done),
        .inv_code(inv_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one request, accept it, then scramble inputs and record five cycles.
    task automatic run_req(input logic [3:0] c, input logic f, input logic [3:0] a,
                           input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm);
        @(negedge clock);
        in_code = c; cnd = f; ra = a; rb = b; val_e = ve; val_m = vm; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_code  = 4'($urandom); cnd = 1'($urandom); ra = 4'($urandom); rb = 4'($urandom);
        val_e    = {$urandom, $urandom}; val_m = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            obs_we[i]   = rf_we;
            obs_addr[i] = rf_addr;
            obs_data[i] = rf_data;
            obs_done[i] = wb_done;
            obs_rdy[i]  = in_ready;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_code = 4'h0; cnd = 1'b0;
        ra = 4'h0; rb = 4'h0; val_e = '0; val_m = '0;
        #12;
        total++;
        if (rf_we !== 1'b0 || rf_addr !== 4'hF || rf_data !== 64'd0 || wb_done !== 1'b0 || inv_code !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: we=%b addr=%h data=%0d done=%b inv=%b, required 0 f 0 0 0",
                     rf_we, rf_addr, rf_data, wb_done, inv_code);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_cmov;
        run_req(4'h2, 1'b0, 4'h0, 4'h1, 64'd21, 64'd0);
        total++;
        if (obs_we[0] !== 1'b0 || obs_done[0] !== 1'b1 || obs_addr[0] !== 4'hF || obs_data[0] !== 64'd0) begin
            bad++;
            $display("[TB] FAIL cmov_false: we=%b done=%b addr=%h data=%0d, required we=0 done=1 addr=f data=0",
                     obs_we[0], obs_done[0], obs_addr[0], obs_data[0]);
        end
        total++;
        if (obs_rdy[0] !== 1'b0 || obs_rdy[1] !== 1'b1 || obs_done[1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cmov_false_ready: rdy0=%b rdy1=%b done1=%b, required 0 1 0",
                     obs_rdy[0], obs_rdy[1], obs_done[1]);
        end
        run_req(4'h2, 1'b1, 4'h0, 4'h1, 64'd21, 64'd0);
        total++;
        if (obs_we[0] !== 1'b1 || obs_addr[0] !== 4'h1 || obs_data[0] !== 64'd21 || obs_done[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cmov_true_write: we=%b addr=%h data=%0d done=%b, required 1 1 21 0",
                     obs_we[0], obs_addr[0], obs_data[0], obs_done[0]);
        end
        total++;
        if (obs_we[1] !== 1'b0 || obs_done[1] !== 1'b1 || obs_done[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cmov_true_done: we1=%b done1=%b done2=%b, required 0 1 0",
                     obs_we[1], obs_done[1], obs_done[2]);
        end
    endtask

    task automatic test_popq;
        run_req(4'hB, 1'b0, 4'h5, 4'h0, 64'd256, 64'd10);
        total++;
        if (obs_we[0] !== 1'b1 || obs_addr[0] !== 4'h4 || obs_data[0] !== 64'd256) begin
            bad++;
            $display("[TB] FAIL popq_e_write: we=%b addr=%h data=%0d, required 1 4 256",
                     obs_we[0], obs_addr[0], obs_data[0]);
        end
        total++;
        if (obs_we[1] !== 1'b1 || obs_addr[1] !== 4'h5 || obs_data[1] !== 64'd10) begin
            bad++;
            $display("[TB] FAIL popq_m_write: we=%b addr=%h data=%0d, required 1 5 10",
                     obs_we[1], obs_addr[1], obs_data[1]);
        end
        total++;
        if (obs_done[0] !== 1'b0 || obs_done[1] !== 1'b0 || obs_done[2] !== 1'b1 || obs_we[2] !== 1'b0 || obs_rdy[3] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL popq_done: done=%b%b%b we2=%b rdy3=%b, required 001 0 1",
                     obs_done[0], obs_done[1], obs_done[2], obs_we[2], obs_rdy[3]);
        end
    endtask

    // popq %rsp: the memory value must be the last thing written to %rsp.
    task automatic test_popq_rsp;
        run_req(4'hB, 1'b0, 4'h4, 4'h0, 64'd256, 64'd10);
`ifdef WB_SAME_DST_MERGE_EN
        total++;
        if (obs_we[0] !== 1'b1 || obs_addr[0] !== 4'h4 || obs_data[0] !== 64'd10 || obs_we[1] !== 1'b0 || obs_done[1] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL popq_rsp_merged: we0=%b addr0=%h data0=%0d we1=%b done1=%b, required 1 4 10 0 1",
                     obs_we[0], obs_addr[0], obs_data[0], obs_we[1], obs_done[1]);
        end
`else
        total++;
        if (obs_we[0] !== 1'b1 || obs_addr[0] !== 4'h4 || obs_data[0] !== 64'd256) begin
            bad++;
            $display("[TB] FAIL popq_rsp_first: we=%b addr=%h data=%0d, required 1 4 256",
                     obs_we[0], obs_addr[0], obs_data[0]);
        end
        total++;
        if (obs_we[1] !== 1'b1 || obs_addr[1] !== 4'h4 || obs_data[1] !== 64'd10 || obs_done[2] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL popq_rsp_final: we=%b addr=%h data=%0d done2=%b, required 1 4 10 1",
                     obs_we[1], obs_addr[1], obs_data[1], obs_done[2]);
        end
`endif
    endtask

    task automatic test_decode;
        logic [3:0]  codes [8]  = '{4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'h5, 4'h0, 4'h7};
        logic        wr    [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  addr  [8]  = '{4'h7, 4'h2, 4'h4, 4'h4, 4'h4, 4'h3, 4'hF, 4'hF};
        logic [63:0] data  [8]  = '{64'd100, 64'd100, 64'd100, 64'd100, 64'd100, 64'd55, 64'd0, 64'd0};
        for (int k = 0; k < 8; k++) begin
            run_req(codes[k], 1'b0, 4'h3, (k == 1) ? 4'h2 : 4'h7, 64'd100, 64'd55);
            total++;
            if (obs_we[0] !== wr[k] || obs_addr[0] !== addr[k] || obs_data[0] !== data[k] ||
                obs_done[wr[k] ? 1 : 0] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL decode_%h: we=%b addr=%h data=%0d done0=%b done1=%b, required we=%b addr=%h data=%0d",
                         codes[k], obs_we[0], obs_addr[0], obs_data[0], obs_done[0], obs_done[1],
                         wr[k], addr[k], data[k]);
            end
        end
    endtask

    task automatic test_invalid;
        run_req(4'h4, 1'b1, 4'h1, 4'h2, 64'd7, 64'd8);
        total++;
        if (obs_we[0] !== 1'b0 || obs_done[0] !== 1'b1 || inv_code !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmmovq: we=%b done=%b inv=%b, required 0 1 0", obs_we[0], obs_done[0], inv_code);
        end
        run_req(4'hD, 1'b1, 4'h1, 4'h2, 64'd7, 64'd8);
        total++;
        if (obs_we[0] !== 1'b0 || obs_we[1] !== 1'b0 || obs_done[0] !== 1'b1 || inv_code !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_code: we=%b%b done=%b inv=%b, required 00 1 1",
                     obs_we[0], obs_we[1], obs_done[0], inv_code);
        end
        run_req(4'h3, 1'b0, 4'h0, 4'h6, 64'd9, 64'd0);
        total++;
        if (inv_code !== 1'b1 || obs_we[0] !== 1'b1 || obs_addr[0] !== 4'h6) begin
            bad++;
            $display("[TB] FAIL inv_sticky: inv=%b we=%b addr=%h, required 1 1 6", inv_code, obs_we[0], obs_addr[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic saw_we;
        @(negedge clock);
        in_code = 4'hB; cnd = 1'b0; ra = 4'h5; rb = 4'h0; val_e = 64'd256; val_m = 64'd10; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_addr !== 4'h4) begin
            bad++;
            $display("[TB] FAIL mid_wr_e: we=%b addr=%h, required 1 4", rf_we, rf_addr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (rf_we !== 1'b0 || rf_addr !== 4'hF || rf_data !== 64'd0 || wb_done !== 1'b0 || inv_code !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs: we=%b addr=%h data=%0d done=%b inv=%b, required 0 f 0 0 0",
                     rf_we, rf_addr, rf_data, wb_done, inv_code);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reset_ready: in_ready=%b, required 1", in_ready);
        end
        saw_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rf_we !== 1'b0 || wb_done !== 1'b0) saw_we = 1'b1;
            @(posedge clock);
            #1;
        end
        total++;
        if (saw_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_discard: activity seen=%b, required 0", saw_we);
        end
    endtask

    initial begin
        test_reset;
        test_cmov;
        test_popq;
        test_popq_rsp;
        test_decode;
        test_invalid;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
